// File: rtl/uart_waveform_receiver_if.sv
// Signal bundle between the waveform UART receiver (master) and its consumer (slave).
interface uart_waveform_receiver_if;
    logic        uart;
    logic        sample_valid;
    logic [13:0] sample_data;
    logic [7:0]  sample_index;
    logic        frame_done;
    logic [23:0] pulse_height;
    logic        byte_valid;
    logic [7:0]  rx_byte;
    logic        err_frame;
    logic        err_format;
    logic        err_index;
    logic        err_gap;

    modport master (
        input  uart,
        output sample_valid, sample_data, sample_index, frame_done, pulse_height,
        output byte_valid, rx_byte, err_frame, err_format, err_index, err_gap
    );

    modport slave (
        output uart,
        input  sample_valid, sample_data, sample_index, frame_done, pulse_height,
        input  byte_valid, rx_byte, err_frame, err_format, err_index, err_gap
    );
endinterface

// File: rtl/uart_waveform_receiver.sv
// 8N1 UART byte receiver feeding a frame assembler: 32 records of {sample, index}
// followed by a 24-bit pulse-height trailer, with framing, format, index and gap checks.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge; gap timer runs mid-frame
// START | waiting half a bit to confirm the start bit
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit
module uart_waveform_receiver #(
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_CLKS     = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    uart_waveform_receiver_if.master bus
);
    localparam int TW = 10;
    localparam int GW = $clog2(GAP_CLKS + 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CLKS - 1);
    localparam logic [5:0]    REC_TRAILER = 6'd32;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
    logic [TW-1:0] bit_tmr_q, bit_tmr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [GW-1:0] gap_tmr_q, gap_tmr_d;
    logic [5:0]  rec_cnt_q, rec_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  byte0_q, byte0_d, byte1_q, byte1_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        sample_valid_q, sample_valid_d;
    logic [13:0] sample_data_q, sample_data_d;
    logic [7:0]  sample_index_q, sample_index_d;
    logic        frame_done_q, frame_done_d;
    logic [23:0] pulse_height_q, pulse_height_d;
    logic        err_frame_q, err_frame_d, err_format_q, err_format_d;
    logic        err_index_q, err_index_d, err_gap_q, err_gap_d;
    logic        fall, asm_busy;

    assign fall     = rx_prev_q & ~sync2_q;
    assign asm_busy = (rec_cnt_q != 6'd0) || (byte_cnt_q != 2'd0);

    always_comb begin
        state_d        = state_q;
        sync1_d        = bus.uart;
        sync2_d        = sync1_q;
        rx_prev_d      = sync2_q;
        bit_tmr_d      = bit_tmr_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        gap_tmr_d      = GAP_LOAD;
        rec_cnt_d      = rec_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        byte0_d        = byte0_q;
        byte1_d        = byte1_q;
        byte_valid_d   = 1'b0;
        rx_byte_d      = rx_byte_q;
        sample_valid_d = 1'b0;
        sample_data_d  = sample_data_q;
        sample_index_d = sample_index_q;
        frame_done_d   = 1'b0;
        pulse_height_d = pulse_height_q;
        err_frame_d    = 1'b0;
        err_format_d   = 1'b0;
        err_index_d    = 1'b0;
        err_gap_d      = 1'b0;

        // Frame assembler consumes each good byte in its byte_valid cycle.
        if (byte_valid_q) begin
            case (byte_cnt_q)
                2'd0: begin
                    byte0_d      = rx_byte_q;
                    err_format_d = (rec_cnt_q != REC_TRAILER) && (rx_byte_q[7:6] != 2'b00);
                    byte_cnt_d   = 2'd1;
                end
                2'd1: begin
                    byte1_d    = rx_byte_q;
                    byte_cnt_d = 2'd2;
                end
                default: begin
                    byte_cnt_d = 2'd0;
                    if (rec_cnt_q == REC_TRAILER) begin
                        pulse_height_d = {byte0_q, byte1_q, rx_byte_q};
                        frame_done_d   = 1'b1;
                        rec_cnt_d      = 6'd0;
                    end else begin
                        sample_valid_d = 1'b1;
                        sample_data_d  = {byte0_q[5:0], byte1_q};
                        sample_index_d = rx_byte_q;
                        err_index_d    = (rx_byte_q != {2'b00, rec_cnt_q});
                        rec_cnt_d      = rec_cnt_q + 6'd1;
                    end
                end
            endcase
        end

        case (state_q)
            IDLE: begin
                if (asm_busy) begin
                    if (gap_tmr_q == '0) begin
                        err_gap_d  = 1'b1;
                        rec_cnt_d  = 6'd0;
                        byte_cnt_d = 2'd0;
                    end else begin
                        gap_tmr_d = gap_tmr_q - GW'(1);
                    end
                end
                if (fall) begin
                    gap_tmr_d = GAP_LOAD;
                    bit_tmr_d = HALF_LOAD;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_tmr_q == '0) begin
                    bit_tmr_d = BIT_LOAD;
                    bit_cnt_d = 3'd0;
                    state_d   = sync2_q ? IDLE : DATA;
                end else begin
                    bit_tmr_d = bit_tmr_q - TW'(1);
                end
            end
            DATA: begin
                if (bit_tmr_q == '0) begin
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_tmr_d = BIT_LOAD;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end else begin
                    bit_tmr_d = bit_tmr_q - TW'(1);
                end
            end
            default: begin
                if (bit_tmr_q == '0) begin
                    state_d = IDLE;
                    if (sync2_q) begin
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shift_q;
                    end else begin
                        err_frame_d = 1'b1;
                        rec_cnt_d   = 6'd0;
                        byte_cnt_d  = 2'd0;
                    end
                end else begin
                    bit_tmr_d = bit_tmr_q - TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            rx_prev_q      <= 1'b1;
            bit_tmr_q      <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            gap_tmr_q      <= '0;
            rec_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            byte0_q        <= '0;
            byte1_q        <= '0;
            byte_valid_q   <= 1'b0;
            rx_byte_q      <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_index_q <= '0;
            frame_done_q   <= 1'b0;
            pulse_height_q <= '0;
            err_frame_q    <= 1'b0;
            err_format_q   <= 1'b0;
            err_index_q    <= 1'b0;
            err_gap_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            rx_prev_q      <= rx_prev_d;
            bit_tmr_q      <= bit_tmr_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            gap_tmr_q      <= gap_tmr_d;
            rec_cnt_q      <= rec_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            byte0_q        <= byte0_d;
            byte1_q        <= byte1_d;
            byte_valid_q   <= byte_valid_d;
            rx_byte_q      <= rx_byte_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            sample_index_q <= sample_index_d;
            frame_done_q   <= frame_done_d;
            pulse_height_q <= pulse_height_d;
            err_frame_q    <= err_frame_d;
            err_format_q   <= err_format_d;
            err_index_q    <= err_index_d;
            err_gap_q      <= err_gap_d;
        end
    end

    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_data  = sample_data_q;
    assign bus.sample_index = sample_index_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.pulse_height = pulse_height_q;
    assign bus.byte_valid   = byte_valid_q;
    assign bus.rx_byte      = rx_byte_q;
    assign bus.err_frame    = err_frame_q;
    assign bus.err_format   = err_format_q;
    assign bus.err_index    = err_index_q;
    assign bus.err_gap      = err_gap_q;
endmodule

// File: tb/tb_uart_waveform_receiver.sv
// Directed bench for uart_waveform_receiver: full frames, framing/glitch/index/gap
// faults and mid-byte reset, with hand-computed expectations.
module tb_uart_waveform_receiver;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_waveform_receiver_if bus();

    uart_waveform_receiver #(.CLKS_PER_BIT(CPB), .GAP_CLKS(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Event recorder sampled on the falling edge, away from the active edge.
    logic [13:0] samp_data[$];
    logic [7:0]  samp_idx[$];
    logic        samp_eidx[$];
    int n_fd = 0, n_bv = 0, n_ef = 0, n_efmt = 0, n_ei = 0, n_eg = 0, n_wide = 0;
    logic [23:0] last_ph = '0;
    logic [6:0]  prev_p = '0;

    always @(negedge clk) begin
        logic [6:0] cur_p;
        cur_p = {bus.sample_valid, bus.frame_done, bus.byte_valid, bus.err_frame,
                 bus.err_format, bus.err_index, bus.err_gap};
        if (bus.sample_valid) begin
            samp_data.push_back(bus.sample_data);
            samp_idx.push_back(bus.sample_index);
            samp_eidx.push_back(bus.err_index);
        end
        if (bus.frame_done) begin n_fd++; last_ph = bus.pulse_height; end
        if (bus.byte_valid) n_bv++;
        if (bus.err_frame)  n_ef++;
        if (bus.err_format) n_efmt++;
        if (bus.err_index)  n_ei++;
        if (bus.err_gap)    n_eg++;
        if ((cur_p & prev_p) != 7'd0) n_wide++;
        if (bus.err_frame && bus.err_gap) n_wide++;
        prev_p = cur_p;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.uart = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.uart = b[k];
            repeat (CPB) @(negedge clk);
        end
        bus.uart = stop_bit;
        repeat (CPB) @(negedge clk);
        bus.uart = 1'b1;
    endtask

    task automatic send_record(input logic [13:0] s, input logic [7:0] idx);
        send_byte({2'b00, s[13:8]}, 1'b1);
        send_byte(s[7:0], 1'b1);
        send_byte(idx, 1'b1);
    endtask

    task automatic send_frame(input int idx_rec, input logic [7:0] idx_val);
        for (int i = 0; i < 32; i++)
            send_record(14'(i * 100), (i == idx_rec) ? idx_val : 8'(i));
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        bus.uart = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.sample_valid, bus.frame_done, bus.byte_valid, bus.err_frame,
             bus.err_format, bus.err_index, bus.err_gap} !== 7'd0) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 0000000", {bus.sample_valid,
                bus.frame_done, bus.byte_valid, bus.err_frame, bus.err_format, bus.err_index, bus.err_gap});
        end
        n_cmp++;
        if ({bus.sample_data, bus.sample_index, bus.pulse_height, bus.rx_byte} !== 54'd0) begin
            n_bad++; $display("FAIL reset_data: got data=%h idx=%h ph=%h rx=%h want all 0",
                bus.sample_data, bus.sample_index, bus.pulse_height, bus.rx_byte);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_full_frame();
        int b = samp_data.size();
        int fd0 = n_fd, bv0 = n_bv, er0 = n_ef + n_efmt + n_ei + n_eg;
        send_frame(-1, 8'h00);
        n_cmp++;
        if (samp_data.size() - b !== 32) begin
            n_bad++; $display("FAIL full_count: got %0d samples want 32", samp_data.size() - b);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (samp_data[b+i] !== 14'(i * 100) || samp_idx[b+i] !== 8'(i)) begin
                n_bad++; $display("FAIL full_sample[%0d]: got %0d/%0d want %0d/%0d",
                    i, samp_data[b+i], samp_idx[b+i], i * 100, i);
            end
        end
        n_cmp++;
        if (n_fd - fd0 !== 1 || last_ph !== 24'h123456) begin
            n_bad++; $display("FAIL full_trailer: got done=%0d ph=%h want 1 123456", n_fd - fd0, last_ph);
        end
        n_cmp++;
        if (n_bv - bv0 !== 99) begin
            n_bad++; $display("FAIL full_bytes: got %0d want 99", n_bv - bv0);
        end
        n_cmp++;
        if (n_ef + n_efmt + n_ei + n_eg - er0 !== 0) begin
            n_bad++; $display("FAIL full_errors: got %0d want 0", n_ef + n_efmt + n_ei + n_eg - er0);
        end
    endtask

    task automatic test_frame_error();
        int bv0 = n_bv, ef0 = n_ef, eg0 = n_eg;
        int b;
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (n_ef - ef0 !== 1) begin
            n_bad++; $display("FAIL ferr_pulse: got %0d want 1", n_ef - ef0);
        end
        n_cmp++;
        if (n_bv - bv0 !== 1) begin
            n_bad++; $display("FAIL ferr_bytes: got %0d want 1", n_bv - bv0);
        end
        b = samp_data.size();
        send_frame(-1, 8'h00);
        n_cmp++;
        if (samp_data.size() - b !== 32 || samp_data[b+31] !== 14'd3100 || samp_idx[b] !== 8'd0) begin
            n_bad++; $display("FAIL ferr_next_frame: got n=%0d s31=%0d idx0=%0d want 32 3100 0",
                samp_data.size() - b, samp_data[b+31], samp_idx[b]);
        end
        n_cmp++;
        if (n_ef - ef0 !== 1 || n_eg - eg0 !== 0) begin
            n_bad++; $display("FAIL ferr_after: got ef=%0d eg=%0d want 1 0", n_ef - ef0, n_eg - eg0);
        end
    endtask

    task automatic test_glitch();
        int bv0 = n_bv, er0 = n_ef + n_efmt + n_ei + n_eg;
        bus.uart = 1'b0;
        @(negedge clk);
        bus.uart = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (n_bv - bv0 !== 0 || n_ef + n_efmt + n_ei + n_eg - er0 !== 0) begin
            n_bad++; $display("FAIL glitch: got bytes=%0d errs=%0d want 0 0",
                n_bv - bv0, n_ef + n_efmt + n_ei + n_eg - er0);
        end
    endtask

    task automatic test_index();
        int b = samp_data.size();
        int ei0 = n_ei, fd0 = n_fd;
        send_frame(3, 8'h07);
        n_cmp++;
        if (samp_idx[b+3] !== 8'h07 || samp_eidx[b+3] !== 1'b1 || samp_data[b+3] !== 14'd300) begin
            n_bad++; $display("FAIL index_rec3: got idx=%h eidx=%b data=%0d want 07 1 300",
                samp_idx[b+3], samp_eidx[b+3], samp_data[b+3]);
        end
        n_cmp++;
        if (n_ei - ei0 !== 1 || samp_idx[b+4] !== 8'd4 || samp_eidx[b+4] !== 1'b0) begin
            n_bad++; $display("FAIL index_count: got ei=%0d idx4=%0d eidx4=%b want 1 4 0",
                n_ei - ei0, samp_idx[b+4], samp_eidx[b+4]);
        end
        n_cmp++;
        if (samp_data.size() - b !== 32 || n_fd - fd0 !== 1) begin
            n_bad++; $display("FAIL index_frame: got n=%0d done=%0d want 32 1", samp_data.size() - b, n_fd - fd0);
        end
    endtask

    task automatic test_gap();
        int b = samp_data.size();
        int eg0 = n_eg, efmt0 = n_efmt, fd0 = n_fd;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                send_byte(8'hC0, 1'b1);
                send_byte(8'd200, 1'b1);
                send_byte(8'd2, 1'b1);
            end else begin
                send_record(14'(i * 100), 8'(i));
            end
        end
        send_byte({2'b00, 6'(500 >> 8)}, 1'b1);
        send_byte(8'(500 & 255), 1'b1);
        repeat (55) @(negedge clk);
        n_cmp++;
        if (n_eg - eg0 !== 0) begin
            n_bad++; $display("FAIL gap_early: got %0d want 0", n_eg - eg0);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (n_eg - eg0 !== 1) begin
            n_bad++; $display("FAIL gap_pulse: got %0d want 1", n_eg - eg0);
        end
        n_cmp++;
        if (n_efmt - efmt0 !== 1 || samp_data[b+2] !== 14'd200 || samp_data.size() - b !== 5) begin
            n_bad++; $display("FAIL gap_format: got fmt=%0d s2=%0d n=%0d want 1 200 5",
                n_efmt - efmt0, samp_data[b+2], samp_data.size() - b);
        end
        b = samp_data.size();
        send_frame(-1, 8'h00);
        n_cmp++;
        if (samp_data.size() - b !== 32 || samp_data[b] !== 14'd0 || samp_data[b+5] !== 14'd500
            || samp_idx[b+31] !== 8'd31 || n_fd - fd0 !== 1 || n_eg - eg0 !== 1) begin
            n_bad++; $display("FAIL gap_next_frame: got n=%0d s0=%0d s5=%0d i31=%0d done=%0d eg=%0d want 32 0 500 31 1 1",
                samp_data.size() - b, samp_data[b], samp_data[b+5], samp_idx[b+31], n_fd - fd0, n_eg - eg0);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        int er0 = n_ef + n_efmt + n_ei + n_eg, fd0 = n_fd;
        for (int i = 0; i < 10; i++) send_record(14'(i * 100), 8'(i));
        send_byte(8'h03, 1'b1);
        bus.uart = 1'b0;
        repeat (10) @(negedge clk);
        reset_n  = 1'b0;
        bus.uart = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.sample_valid, bus.frame_done, bus.byte_valid, bus.sample_data,
             bus.sample_index, bus.pulse_height, bus.rx_byte} !== 57'd0) begin
            n_bad++; $display("FAIL rmid_outputs: got data=%0d idx=%0d ph=%h rx=%h want all 0",
                bus.sample_data, bus.sample_index, bus.pulse_height, bus.rx_byte);
        end
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (n_ef + n_efmt + n_ei + n_eg - er0 !== 0) begin
            n_bad++; $display("FAIL rmid_errors: got %0d want 0", n_ef + n_efmt + n_ei + n_eg - er0);
        end
        b = samp_data.size();
        send_frame(-1, 8'h00);
        n_cmp++;
        if (samp_data.size() - b !== 32 || samp_data[b+10] !== 14'd1000 || samp_idx[b+31] !== 8'd31
            || n_fd - fd0 !== 1 || last_ph !== 24'h123456) begin
            n_bad++; $display("FAIL rmid_next_frame: got n=%0d s10=%0d i31=%0d done=%0d ph=%h want 32 1000 31 1 123456",
                samp_data.size() - b, samp_data[b+10], samp_idx[b+31], n_fd - fd0, last_ph);
        end
    endtask

    task automatic test_pulse_width();
        n_cmp++;
        if (n_wide !== 0) begin
            n_bad++; $display("FAIL pulse_width: got %0d overlong/overlapping pulses want 0", n_wide);
        end
    endtask

    initial begin
        bus.uart = 1'b1;
        test_reset();
        test_full_frame();
        test_frame_error();
        test_glitch();
        test_index();
        test_gap();
        test_reset_mid();
        test_pulse_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
